// File: rtl/mult_share_scheduler.sv
// Round-robin scheduler sharing one signed 16x16 Wallace multiplier.
// One operation in flight: grant, multiply, then hold the response.
module wallace_signed_multiplier_16 (
  input  logic signed [15:0] a,
  input  logic signed [15:0] b,
  output logic signed [31:0] p
);

  logic [31:0] a_ext;
  logic [31:0] l0 [16];
  logic [31:0] l1 [11];
  logic [31:0] l2 [8];
  logic [31:0] l3 [6];
  logic [31:0] l4 [4];
  logic [31:0] l5 [3];
  logic [31:0] l6 [2];

  function automatic logic [63:0] csa(
    input logic [31:0] x,
    input logic [31:0] y,
    input logic [31:0] z
  );
    logic [31:0] s;
    logic [31:0] c;
    s = x ^ y ^ z;
    c = ((x & y) | (x & z) | (y & z)) << 1;
    return {s, c};
  endfunction

  assign a_ext = {{16{a[15]}}, a};

  // b[15] weighs -2^15: its row is inverted and the +1 enters the final add
  always_comb begin
    for (int i = 0; i < 15; i++) begin
      l0[i] = b[i] ? (a_ext << i) : 32'd0;
    end
    l0[15] = b[15] ? ~(a_ext << 15) : 32'd0;
    for (int k = 0; k < 5; k++) begin
      {l1[2*k], l1[2*k+1]} = csa(l0[3*k], l0[3*k+1], l0[3*k+2]);
    end
    l1[10] = l0[15];
    for (int k = 0; k < 3; k++) begin
      {l2[2*k], l2[2*k+1]} = csa(l1[3*k], l1[3*k+1], l1[3*k+2]);
    end
    l2[6] = l1[9];
    l2[7] = l1[10];
    for (int k = 0; k < 2; k++) begin
      {l3[2*k], l3[2*k+1]} = csa(l2[3*k], l2[3*k+1], l2[3*k+2]);
    end
    l3[4] = l2[6];
    l3[5] = l2[7];
    for (int k = 0; k < 2; k++) begin
      {l4[2*k], l4[2*k+1]} = csa(l3[3*k], l3[3*k+1], l3[3*k+2]);
    end
    {l5[0], l5[1]} = csa(l4[0], l4[1], l4[2]);
    l5[2] = l4[3];
    {l6[0], l6[1]} = csa(l5[0], l5[1], l5[2]);
    p = l6[0] + l6[1] + {31'd0, b[15]};
  end

endmodule

module mult_share_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [NUM_REQ*16-1:0]   req_a,
  input  logic [NUM_REQ*16-1:0]   req_b,
  output logic                    resp_valid,
  input  logic                    resp_ready,
  output logic [31:0]             resp_product,
  output logic [ID_W-1:0]         resp_id,
  output logic                    busy,
  output logic [15:0]             op_count
);

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    RESP
  } state_t;

  state_t state;
  state_t state_nx;

  logic [ID_W-1:0]    rr_ptr;
  logic [ID_W-1:0]    grant;
  logic [ID_W-1:0]    id_reg;
  logic               found;
  logic               req_hs;
  logic               resp_hs;
  logic signed [15:0] a_reg;
  logic signed [15:0] b_reg;
  logic signed [31:0] mul_p;
  logic signed [31:0] prod_reg;

  function automatic logic [ID_W-1:0] wrap_idx(
    input logic [ID_W-1:0] base,
    input int              k
  );
    int s;
    s = (int'(base) + k) % NUM_REQ;
    return ID_W'(s);
  endfunction

  wallace_signed_multiplier_16 u_mul (
    .a (a_reg),
    .b (b_reg),
    .p (mul_p)
  );

  // descending scan so the nearest valid slot after rr_ptr wins
  always_comb begin
    grant = '0;
    found = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req_valid[wrap_idx(rr_ptr, k)]) begin
        grant = wrap_idx(rr_ptr, k);
        found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (req_hs) state_nx = MUL;
      MUL:     state_nx = RESP;
      RESP:    if (resp_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    req_ready  = '0;
    busy       = (state != IDLE);
    resp_valid = (state == RESP);
    if (state == IDLE && !rst && found) begin
      req_ready[grant] = 1'b1;
    end
  end

  assign req_hs       = |(req_valid & req_ready);
  assign resp_hs      = resp_valid & resp_ready;
  assign resp_product = prod_reg;
  assign resp_id      = id_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr   <= '0;
      id_reg   <= '0;
      a_reg    <= '0;
      b_reg    <= '0;
      prod_reg <= '0;
      op_count <= '0;
    end else begin
      if (req_hs) begin
        a_reg  <= req_a[{grant, 4'b0000} +: 16];
        b_reg  <= req_b[{grant, 4'b0000} +: 16];
        id_reg <= grant;
        rr_ptr <= wrap_idx(grant, 1);
      end
      if (state == MUL) begin
        prod_reg <= mul_p;
      end
      if (resp_hs) begin
        op_count <= op_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_mult_share_scheduler.sv
// Self-checking bench for mult_share_scheduler.
// Transaction-level reference model with randomized traffic.
module tb_mult_share_scheduler;

  localparam int N    = 4;
  localparam int ID_W = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*16-1:0] req_a;
  logic [N*16-1:0] req_b;
  logic            resp_valid;
  logic            resp_ready;
  logic [31:0]     resp_product;
  logic [ID_W-1:0] resp_id;
  logic            busy;
  logic [15:0]     op_count;

  int checks = 0;
  int errors = 0;
  int exp_ptr = 0;
  int exp_count = 0;

  mult_share_scheduler #(
    .NUM_REQ (N),
    .ID_W    (ID_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_a        (req_a),
    .req_b        (req_b),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_product (resp_product),
    .resp_id      (resp_id),
    .busy         (busy),
    .op_count     (op_count)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  function automatic int model_grant(input int ptr, input logic [N-1:0] v);
    for (int k = 0; k < N; k++) begin
      if (v[(ptr + k) % N]) return (ptr + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [31:0] model_mul(input logic [15:0] a, input logic [15:0] b);
    int sa;
    int sb;
    sa = int'($signed(a));
    sb = int'($signed(b));
    return 32'(sa * sb);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int r, input logic [15:0] a, input logic [15:0] b);
    req_valid[r] = 1'b1;
    req_a[16*r +: 16] = a;
    req_b[16*r +: 16] = b;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = '0;
    step();
    rst = 1'b0;
    exp_ptr = 0;
    exp_count = 0;
  endtask

  task automatic run_op(input int r, input logic [15:0] a, input logic [15:0] b,
                        output logic [31:0] p, output int id, output int ok);
    ok = 0;
    p = '0;
    id = -1;
    set_req(r, a, b);
    resp_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      if (req_ready[r]) begin
        ok = 1;
        step();
        break;
      end
      step();
    end
    req_valid[r] = 1'b0;
    if (ok == 0) return;
    ok = 0;
    for (int i = 0; i < 8; i++) begin
      #1;
      if (resp_valid) begin
        p = resp_product;
        id = int'(resp_id);
        ok = 1;
        step();
        break;
      end
      step();
    end
    if (ok == 1) begin
      exp_ptr = (r + 1) % N;
      exp_count++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    resp_ready = 1'b0;
    req_valid = '1;
    req_a = {$urandom, $urandom};
    req_b = {$urandom, $urandom};
    step();
    #1;
    checks++;
    if (req_ready !== 4'b0000) begin
      errors++;
      $display("FAIL reset_ready got %b exp 0000", req_ready);
    end
    step();
    rst = 1'b0;
    req_valid = '0;
    exp_ptr = 0;
    exp_count = 0;
    #1;
    checks++;
    if ({resp_valid, busy} !== 2'b00) begin
      errors++;
      $display("FAIL reset_flags got valid=%b busy=%b exp 0 0", resp_valid, busy);
    end
    checks++;
    if (resp_product !== 32'd0 || resp_id !== 2'd0) begin
      errors++;
      $display("FAIL reset_resp got %h/%0d exp 0/0", resp_product, resp_id);
    end
    checks++;
    if (op_count !== 16'd0) begin
      errors++;
      $display("FAIL reset_count got %0d exp 0", op_count);
    end
  endtask

  task automatic test_basic();
    set_req(0, 16'h2771, 16'h0F67);
    resp_ready = 1'b1;
    #1;
    checks++;
    if (req_ready !== 4'b0001) begin
      errors++;
      $display("FAIL basic_ready got %b exp 0001", req_ready);
    end
    step();
    req_valid = '0;
    exp_ptr = 1;
    checks++;
    if (busy !== 1'b1 || resp_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_mul got busy=%b valid=%b exp 1 0", busy, resp_valid);
    end
    step();
    checks++;
    if (resp_valid !== 1'b1 || resp_product !== 32'd39812471 || resp_id !== 2'd0) begin
      errors++;
      $display("FAIL basic_resp got %b %0d %0d exp 1 39812471 0",
               resp_valid, $signed(resp_product), resp_id);
    end
    step();
    exp_count++;
    checks++;
    if (resp_valid !== 1'b0 || op_count !== 16'd1) begin
      errors++;
      $display("FAIL basic_count got valid=%b cnt=%0d exp 0 1", resp_valid, op_count);
    end
  endtask

  task automatic test_extremes();
    logic [15:0] ta [3];
    logic [15:0] tb [3];
    logic [31:0] tp [3];
    logic [31:0] p;
    int id;
    int ok;
    ta[0] = 16'hA000; tb[0] = 16'd3;    tp[0] = 32'hFFFEE000;
    ta[1] = 16'h8000; tb[1] = 16'h8000; tp[1] = 32'h40000000;
    ta[2] = 16'h7FFF; tb[2] = 16'h8000; tp[2] = 32'hC0008000;
    for (int i = 0; i < 3; i++) begin
      run_op(i, ta[i], tb[i], p, id, ok);
      checks++;
      if (ok !== 1 || p !== tp[i] || id !== i) begin
        errors++;
        $display("FAIL extreme%0d got ok=%0d %h id=%0d exp %h id=%0d",
                 i, ok, p, id, tp[i], i);
      end
    end
    checks++;
    if (op_count !== 16'(exp_count)) begin
      errors++;
      $display("FAIL extreme_count got %0d exp %0d", op_count, exp_count);
    end
  endtask

  task automatic test_round_robin();
    int gid [$];
    int gcyc [$];
    int rid [$];
    logic [31:0] rprod [$];
    logic [15:0] oa [N];
    logic [15:0] ob [N];
    int order [5];
    order = '{0, 1, 2, 3, 0};
    do_reset();
    resp_ready = 1'b1;
    for (int r = 0; r < N; r++) begin
      oa[r] = 16'($urandom);
      ob[r] = 16'($urandom);
      set_req(r, oa[r], ob[r]);
    end
    for (int c = 0; c < 16; c++) begin
      #1;
      for (int r = 0; r < N; r++) begin
        if (req_ready[r]) begin
          gid.push_back(r);
          gcyc.push_back(c);
        end
      end
      if (resp_valid) begin
        rid.push_back(int'(resp_id));
        rprod.push_back(resp_product);
      end
      step();
    end
    req_valid = '0;
    checks++;
    if (gid.size() < 5 || rid.size() < 4) begin
      errors++;
      $display("FAIL rr_counts got grants=%0d resps=%0d exp >=5 >=4",
               gid.size(), rid.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        checks++;
        if (gid[i] !== order[i] || gcyc[i] !== 3 * i) begin
          errors++;
          $display("FAIL rr_grant%0d got id=%0d cyc=%0d exp id=%0d cyc=%0d",
                   i, gid[i], gcyc[i], order[i], 3 * i);
        end
      end
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (rid[i] !== order[i] || rprod[i] !== model_mul(oa[order[i]], ob[order[i]])) begin
          errors++;
          $display("FAIL rr_resp%0d got id=%0d %h exp id=%0d %h", i, rid[i],
                   rprod[i], order[i], model_mul(oa[order[i]], ob[order[i]]));
        end
      end
    end
    do_reset();
  endtask

  task automatic test_backpressure();
    logic [15:0] a;
    logic [15:0] b;
    a = 16'($urandom);
    b = 16'($urandom);
    set_req(1, a, b);
    resp_ready = 1'b0;
    #1;
    checks++;
    if (req_ready !== 4'b0010) begin
      errors++;
      $display("FAIL bp_grant got %b exp 0010", req_ready);
    end
    step();
    req_valid = '0;
    step();
    set_req(3, 16'h1234, 16'h0002);
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++;
      if (resp_valid !== 1'b1 || resp_product !== model_mul(a, b) || resp_id !== 2'd1 ||
          req_ready !== 4'b0000 || op_count !== 16'd0) begin
        errors++;
        $display("FAIL bp_hold%0d got v=%b %h id=%0d rdy=%b cnt=%0d exp 1 %h 1 0000 0",
                 i, resp_valid, resp_product, resp_id, req_ready, op_count, model_mul(a, b));
      end
      step();
    end
    resp_ready = 1'b1;
    #1;
    checks++;
    if (req_ready !== 4'b0000) begin
      errors++;
      $display("FAIL bp_release_ready got %b exp 0000", req_ready);
    end
    step();
    checks++;
    if (req_ready !== 4'b1000 || op_count !== 16'd1 || resp_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_next got rdy=%b cnt=%0d v=%b exp 1000 1 0",
               req_ready, op_count, resp_valid);
    end
    step();
    req_valid = '0;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL bp_busy got %b exp 1", busy);
    end
    do_reset();
  endtask

  task automatic test_reset_mid();
    set_req(2, 16'h0111, 16'h0222);
    resp_ready = 1'b1;
    #1;
    checks++;
    if (req_ready !== 4'b0100) begin
      errors++;
      $display("FAIL rm_grant got %b exp 0100", req_ready);
    end
    step();
    req_valid = '0;
    rst = 1'b1;
    set_req(0, 16'h0003, 16'h0004);
    set_req(2, 16'h0005, 16'h0006);
    #1;
    checks++;
    if (req_ready !== 4'b0000) begin
      errors++;
      $display("FAIL rm_ready_in_rst got %b exp 0000", req_ready);
    end
    step();
    rst = 1'b0;
    req_valid = '0;
    exp_ptr = 0;
    exp_count = 0;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if (resp_valid !== 1'b0 || busy !== 1'b0 || op_count !== 16'd0) begin
        errors++;
        $display("FAIL rm_quiet%0d got v=%b busy=%b cnt=%0d exp 0 0 0",
                 i, resp_valid, busy, op_count);
      end
      step();
    end
    req_valid = 4'b0101;
    #1;
    checks++;
    if (req_ready !== 4'b0001) begin
      errors++;
      $display("FAIL rm_ptr got %b exp 0001", req_ready);
    end
    req_valid = '0;
    step();
  endtask

  task automatic test_random();
    logic [N-1:0] pend;
    logic [15:0] pa [N];
    logic [15:0] pb [N];
    logic [15:0] ext [4];
    logic [N-1:0] exp_ready;
    logic [31:0] o_prod;
    int o_id;
    int outstanding;
    int t;
    int g;
    ext = '{16'h8000, 16'h7FFF, 16'h0000, 16'hFFFF};
    do_reset();
    pend = '0;
    outstanding = 0;
    t = 0;
    o_id = 0;
    o_prod = '0;
    for (int c = 0; c < 3000; c++) begin
      for (int r = 0; r < N; r++) begin
        if (!pend[r]) begin
          if ($urandom_range(0, 2) == 0) begin
            pend[r] = 1'b1;
            pa[r] = ($urandom_range(0, 5) == 0) ? ext[$urandom_range(0, 3)] : 16'($urandom);
            pb[r] = ($urandom_range(0, 5) == 0) ? ext[$urandom_range(0, 3)] : 16'($urandom);
          end
        end else if ($urandom_range(0, 15) == 0) begin
          pend[r] = 1'b0;
        end
        req_valid[r] = pend[r];
        req_a[16*r +: 16] = pa[r];
        req_b[16*r +: 16] = pb[r];
      end
      resp_ready = ($urandom_range(0, 3) != 0);
      #1;
      g = (outstanding == 0) ? model_grant(exp_ptr, pend) : -1;
      exp_ready = (g >= 0) ? N'(1 << g) : '0;
      checks++;
      if (req_ready !== exp_ready || busy !== (outstanding != 0) ||
          resp_valid !== (outstanding != 0 && t >= 2) || op_count !== 16'(exp_count)) begin
        errors++;
        $display("FAIL rand_ctl c=%0d got rdy=%b busy=%b v=%b cnt=%0d exp %b %0d %0d %0d",
                 c, req_ready, busy, resp_valid, op_count, exp_ready,
                 outstanding != 0, outstanding != 0 && t >= 2, 16'(exp_count));
      end
      if (outstanding != 0 && t >= 2) begin
        checks++;
        if (resp_product !== o_prod || int'(resp_id) !== o_id) begin
          errors++;
          $display("FAIL rand_resp c=%0d got %h id=%0d exp %h id=%0d",
                   c, resp_product, resp_id, o_prod, o_id);
        end
      end
      if (outstanding != 0) begin
        if (t >= 2 && resp_ready) begin
          outstanding = 0;
          exp_count++;
        end else begin
          t++;
        end
      end else if (g >= 0) begin
        outstanding = 1;
        t = 1;
        o_id = g;
        o_prod = model_mul(pa[g], pb[g]);
        pend[g] = 1'b0;
        exp_ptr = (g + 1) % N;
      end
      step();
    end
    req_valid = '0;
  endtask

  initial begin
    rst = 1'b1;
    req_valid = '0;
    req_a = '0;
    req_b = '0;
    resp_ready = 1'b0;
    step();
    test_reset();
    test_basic();
    test_extremes();
    test_round_robin();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
